// File: rtl/soc_pkg.sv
// Shared defaults and the feeder state encoding for the systolic array front end.
package soc_pkg;

  localparam int ROW_DEFAULT = 9;
  localparam int COL_DEFAULT = 9;
  localparam int DW_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth shift register that delays one array lane by DEPTH cycles.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage [DEPTH];

  // Shift the lane word one stage per cycle; reset flushes every stage to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A/B operand vectors into a ROW x COL systolic array and sequences one job.
module systolic_feeder
  import soc_pkg::*;
#(
  parameter int ROW = ROW_DEFAULT,
  parameter int COL = COL_DEFAULT,
  parameter int DW  = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW*ROW-1:0] in_a,
  input  logic [DW*COL-1:0] in_b,
  output logic [DW*ROW-1:0] out_a,
  output logic [DW*COL-1:0] out_b,
  output logic              out_sel,
  output logic              busy,
  output logic              done
);

  // The drain has to flush the deepest lane pair, which spans ROW+COL-1 cycles.
  localparam int DRAIN_LEN = ROW + COL - 1;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  feeder_state_e        state_q;
  feeder_state_e        state_d;
  logic [7:0]           len_q;
  logic [7:0]           beat_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 accept;
  logic                 last_beat;
  logic                 drain_end;

  // Accept is derived from the registered state so it never loops through the FSM logic.
  assign accept    = in_valid && (state_q == STREAM);
  assign last_beat = ((beat_cnt + 8'd1) == len_q);
  assign drain_end = (drain_cnt == DRAIN_LAST);

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; start is only looked at while idle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    out_sel  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (len == 8'd0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        out_sel  = 1'b1;
        if (accept && last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_sel = 1'b1;
        if (drain_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job length latch plus the beat and drain counters; both counters rearm while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_cnt  <= '0;
          drain_cnt <= '0;
          if (start) begin
            len_q <= len;
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // A lanes: lane i is delayed i+1 cycles; zero is injected whenever nothing is accepted.
  for (genvar i = 0; i < ROW; i++) begin : g_a_lane
    logic [DW-1:0] lane_d;
    assign lane_d = accept ? in_a[DW*i +: DW] : '0;
    skew_line #(.DEPTH(i + 1), .DW(DW)) u_line (
      .clk (clk),
      .rst (rst),
      .d   (lane_d),
      .q   (out_a[DW*i +: DW])
    );
  end

  // B lanes: lane j is delayed j+1 cycles with the same zero-bubble rule.
  for (genvar j = 0; j < COL; j++) begin : g_b_lane
    logic [DW-1:0] lane_d;
    assign lane_d = accept ? in_b[DW*j +: DW] : '0;
    skew_line #(.DEPTH(j + 1), .DW(DW)) u_line (
      .clk (clk),
      .rst (rst),
      .d   (lane_d),
      .q   (out_b[DW*j +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder with hand-derived lane timing.
module tb_systolic_feeder;

  localparam int ROW = 9;
  localparam int COL = 9;
  localparam int DW  = 32;
  localparam int AW  = DW * ROW;
  localparam int BW  = DW * COL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    len;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic [AW-1:0] out_a;
  logic [BW-1:0] out_b;
  logic          out_sel;
  logic          busy;
  logic          done;

  logic [AW-1:0] exp_a;
  logic [BW-1:0] exp_b;
  int            checks   = 0;
  int            failures = 0;
  int            done_count;
  int            sched [5] = '{1, 0, 0, 2, 3};

  systolic_feeder #(.ROW(ROW), .COL(COL), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_sel  (out_sel),
    .busy     (busy),
    .done     (done)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance one cycle and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checkOutput(tag, AW'(obs), AW'(exp));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " out_a"}, out_a, '0);
    checkOutput({tag, " out_b"}, out_b, '0);
    checkFlag({tag, " out_sel"}, out_sel, 1'b0);
    checkFlag({tag, " in_ready"}, in_ready, 1'b0);
    checkFlag({tag, " busy"}, busy, 1'b0);
    checkFlag({tag, " done"}, done, 1'b0);
  endtask

  // Single-beat job: A lane i = i+1, B lane j = 10*(j+1), in_valid held high.
  task automatic applyStimulus(input string tag);
    start    = 1'b1;
    len      = 8'd1;
    in_valid = 1'b0;
    step();
    start = 1'b0;
    checkFlag($sformatf("%s in_ready n", tag), in_ready, 1'b1);
    checkFlag($sformatf("%s out_sel n", tag), out_sel, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(i + 1);
    for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(10 * (j + 1));
    for (int t = 1; t <= 20; t++) begin
      step();
      for (int i = 0; i < ROW; i++) exp_a[DW*i +: DW] = (t == i + 1) ? DW'(i + 1) : '0;
      for (int j = 0; j < COL; j++) exp_b[DW*j +: DW] = (t == j + 1) ? DW'(10 * (j + 1)) : '0;
      checkOutput($sformatf("%s out_a n+%0d", tag, t), out_a, exp_a);
      checkOutput($sformatf("%s out_b n+%0d", tag, t), out_b, exp_b);
      checkOutput($sformatf("%s a3 n+%0d", tag, t), AW'(out_a[DW*3 +: DW]), (t == 4) ? AW'(4) : '0);
      checkOutput($sformatf("%s b8 n+%0d", tag, t), AW'(out_b[DW*8 +: DW]), (t == 9) ? AW'(90) : '0);
      checkFlag($sformatf("%s done n+%0d", tag, t), done, t == 18);
      checkFlag($sformatf("%s out_sel n+%0d", tag, t), out_sel, t <= 17);
      checkFlag($sformatf("%s busy n+%0d", tag, t), busy, t <= 18);
      checkFlag($sformatf("%s in_ready n+%0d", tag, t), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    step();
    step();
    checkQuiet("reset");
    rst = 1'b0;
    step();
    checkQuiet("idle");

    $display("[TB] single beat job");
    applyStimulus("t1");

    $display("[TB] back-to-back len=9");
    start = 1'b1;
    len   = 8'd9;
    step();
    start = 1'b0;
    checkFlag("t2 in_ready n0", in_ready, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(1);
    for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(1);
    for (int t = 1; t <= 28; t++) begin
      step();
      if (t < 9) begin
        for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(t + 1);
        for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(t + 1);
      end else begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
      end
      for (int i = 0; i < ROW; i++) exp_a[DW*i +: DW] = (t - i >= 1 && t - i <= 9) ? DW'(t - i) : '0;
      for (int j = 0; j < COL; j++) exp_b[DW*j +: DW] = (t - j >= 1 && t - j <= 9) ? DW'(t - j) : '0;
      checkOutput($sformatf("t2 out_a n0+%0d", t), out_a, exp_a);
      checkOutput($sformatf("t2 out_b n0+%0d", t), out_b, exp_b);
      checkFlag($sformatf("t2 done n0+%0d", t), done, t == 26);
      checkFlag($sformatf("t2 in_ready n0+%0d", t), in_ready, t < 9);
    end

    $display("[TB] bubbles len=3");
    start = 1'b1;
    len   = 8'd3;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(1 | (i << 8));
    for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(1 | ((j + 16) << 8));
    for (int t = 1; t <= 24; t++) begin
      step();
      if (t <= 4 && sched[t] != 0) begin
        in_valid = 1'b1;
        for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(sched[t] | (i << 8));
        for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(sched[t] | ((j + 16) << 8));
      end else begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
      end
      for (int i = 0; i < ROW; i++) begin
        exp_a[DW*i +: DW] = '0;
        if (t - 1 - i >= 0 && t - 1 - i <= 4 && sched[t-1-i] != 0)
          exp_a[DW*i +: DW] = DW'(sched[t-1-i] | (i << 8));
      end
      for (int j = 0; j < COL; j++) begin
        exp_b[DW*j +: DW] = '0;
        if (t - 1 - j >= 0 && t - 1 - j <= 4 && sched[t-1-j] != 0)
          exp_b[DW*j +: DW] = DW'(sched[t-1-j] | ((j + 16) << 8));
      end
      checkOutput($sformatf("t3 out_a n0+%0d", t), out_a, exp_a);
      checkOutput($sformatf("t3 out_b n0+%0d", t), out_b, exp_b);
      checkFlag($sformatf("t3 done n0+%0d", t), done, t == 22);
      checkFlag($sformatf("t3 in_ready n0+%0d", t), in_ready, t <= 4);
    end

    $display("[TB] zero length job");
    start = 1'b1;
    len   = 8'd0;
    step();
    start = 1'b0;
    checkFlag("t4 done", done, 1'b1);
    checkFlag("t4 busy", busy, 1'b1);
    checkFlag("t4 in_ready", in_ready, 1'b0);
    checkFlag("t4 out_sel", out_sel, 1'b0);
    checkOutput("t4 out_a", out_a, '0);
    checkOutput("t4 out_b", out_b, '0);
    step();
    checkQuiet("t4 after");

    $display("[TB] reset during drain");
    start = 1'b1;
    len   = 8'd1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(i + 1);
    for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(10 * (j + 1));
    for (int t = 1; t <= 4; t++) step();
    in_valid = 1'b0;
    checkOutput("t5 a3 before reset", AW'(out_a[DW*3 +: DW]), AW'(4));
    checkFlag("t5 out_sel before reset", out_sel, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkQuiet("t5 after reset");
    for (int t = 1; t <= 20; t++) begin
      step();
      checkFlag($sformatf("t5 done quiet %0d", t), done, 1'b0);
      checkFlag($sformatf("t5 busy quiet %0d", t), busy, 1'b0);
    end
    applyStimulus("t5 rerun");

    $display("[TB] start ignored outside idle");
    start = 1'b1;
    len   = 8'd2;
    step();
    len      = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < ROW; i++) in_a[DW*i +: DW] = DW'(7);
    for (int j = 0; j < COL; j++) in_b[DW*j +: DW] = DW'(7);
    step();
    start = 1'b0;
    checkFlag("t6 in_ready beat2", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    checkFlag("t6 in_ready drain", in_ready, 1'b0);
    checkFlag("t6 out_sel drain", out_sel, 1'b1);
    done_count = 0;
    for (int t = 3; t <= 21; t++) begin
      step();
      start = 1'b0;
      if (done) done_count++;
      checkFlag($sformatf("t6 done n0+%0d", t), done, t == 19);
      if (t == 19) begin
        start = 1'b1;
        len   = 8'd1;
      end
      if (t >= 20) checkFlag($sformatf("t6 busy n0+%0d", t), busy, 1'b0);
    end
    start = 1'b0;
    checkOutput("t6 done pulses", AW'(done_count), AW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
